// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: state encoding and sizing helpers shared by the multiplier control and collector
package seq_mult_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  function automatic int cnt_width(input int max_width, input int p);
    return $clog2(2 * max_width / p) + 1;
  endfunction
endpackage

// File: rtl/seq_sign_ext.sv
// seq_sign_ext: replicate din[msb] into every bit above msb when enabled, else pass through
module seq_sign_ext #(
  parameter int N  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  din,
  input  logic [IW-1:0] msb,
  input  logic          en,
  output logic [N-1:0]  dout
);
  // bits above the dynamic sign position take the sign bit, the rest are untouched
  always_comb begin
    for (int i = 0; i < N; i++) dout[i] = (en && i > int'(msb)) ? din[msb] : din[i];
  end
endmodule

// File: rtl/seq_mult_deser.sv
// seq_mult_deser: collects LSD-first product digits into a full-width, optionally sign-extended result
module seq_mult_deser
  import seq_mult_pkg::*;
#(
  parameter int P         = 2,
  parameter int MAX_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [$clog2(MAX_WIDTH/P)+1:0]  bitSize,
  input  logic                            signed_mode,
  input  logic                            digit_valid,
  input  logic [P-1:0]                    digit,
  input  logic                            prod_ready,
  output logic [2*MAX_WIDTH-1:0]          product,
  output logic                            prod_valid,
  output logic                            busy,
  output logic                            overrun
);
  localparam int N    = 2 * MAX_WIDTH;
  localparam int DMAX = MAX_WIDTH / P;
  localparam int CW   = cnt_width(MAX_WIDTH, P);
  localparam int IW   = $clog2(N);
  localparam int BW   = $clog2(MAX_WIDTH / P) + 2;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, ndig_q, ndig_d, ndig_new;
  logic           sgn_q, sgn_d;
  logic [N-1:0]   product_q, product_d, prod_ins, prod_ext;
  logic           prod_valid_q, prod_valid_d, busy_q, busy_d, overrun_q, overrun_d;
  logic [BW-1:0]  bs_eff;
  logic [IW-1:0]  msb;
  logic           last;
  assign bs_eff   = (bitSize == '0 || bitSize > BW'(DMAX)) ? BW'(DMAX) : bitSize;
  assign ndig_new = CW'(2 * bs_eff);
  assign last     = (cnt_q == ndig_q - 1'b1);
  assign msb      = IW'(P * ndig_q - 1);
  // current product with the incoming digit dropped into its slot
  always_comb begin
    prod_ins = product_q;
    prod_ins[P*cnt_q +: P] = digit;
  end
  seq_sign_ext #(.N(N), .IW(IW)) u_sign_ext (
    .din  (prod_ins),
    .msb  (msb),
    .en   (sgn_q),
    .dout (prod_ext)
  );
  // next state: start wins everywhere, digits fill in COLLECT, stray digits flag overrun
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ndig_d    = ndig_q;
    sgn_d     = sgn_q;
    product_d = product_q;
    overrun_d = overrun_q;
    if (start) begin
      state_d   = COLLECT;
      cnt_d     = '0;
      ndig_d    = ndig_new;
      sgn_d     = signed_mode;
      product_d = '0;
      overrun_d = 1'b0;
    end else if (state_q == COLLECT) begin
      if (digit_valid) begin
        cnt_d     = cnt_q + 1'b1;
        product_d = last ? prod_ext : prod_ins;
        state_d   = last ? HOLD : COLLECT;
      end
    end else begin
      overrun_d = overrun_q | digit_valid;
      state_d   = (state_q == HOLD && prod_ready) ? IDLE : state_q;
    end
    prod_valid_d = (state_d == HOLD);
    busy_d       = (state_d == COLLECT);
  end
  // all state and outputs registered, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ndig_q       <= '0;
      sgn_q        <= 1'b0;
      product_q    <= '0;
      prod_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ndig_q       <= ndig_d;
      sgn_q        <= sgn_d;
      product_q    <= product_d;
      prod_valid_q <= prod_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end
  assign product    = product_q;
  assign prod_valid = prod_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_seq_mult_deser.sv
// tb_seq_mult_deser: scoreboard-driven scenario tests for the product collector
module tb_seq_mult_deser;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_mode = 1'b0;
  logic        digit_valid = 1'b0, prod_ready = 1'b0;
  logic [4:0]  bitSize = '0;
  logic [1:0]  digit = '0;
  logic [31:0] product;
  logic        prod_valid, busy, overrun;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  seq_mult_deser #(.P(2), .MAX_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bitSize(bitSize), .signed_mode(signed_mode),
    .digit_valid(digit_valid), .digit(digit), .prod_ready(prod_ready),
    .product(product), .prod_valid(prod_valid), .busy(busy), .overrun(overrun)
  );

  function automatic logic [31:0] model(input logic [31:0] raw, input int w, input bit sm);
    logic [31:0] v;
    v = raw;
    if (sm && raw[2*w-1]) for (int i = 2 * w; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_op(input logic [4:0] bs, input logic sm, input logic rdy);
    start = 1'b1; bitSize = bs; signed_mode = sm; prod_ready = rdy;
    tick;
    start = 1'b0; prod_ready = 1'b0;
  endtask

  task automatic send(input logic [1:0] d);
    digit_valid = 1'b1; digit = d;
    tick;
    digit_valid = 1'b0;
  endtask

  task automatic accept;
    prod_ready = 1'b1;
    tick;
    prod_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (product !== 32'h0) begin n_err++; $display("FAIL reset_product: got %h want 00000000", product); end
    n_cmp++; if ({prod_valid, busy, overrun} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {prod_valid, busy, overrun}); end
    @(negedge clk); rst_n = 1'b1;
    tick;
    send(2'b01);
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL idle_overrun: got %b want 1", overrun); end
    n_cmp++; if (prod_valid !== 1'b0) begin n_err++; $display("FAIL idle_no_valid: got %b want 0", prod_valid); end
  endtask

  task automatic test_unsigned;
    logic [1:0] d[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] raw = '0;
    for (int i = 0; i < 4; i++) raw[2*i +: 2] = d[i];
    begin_op(5'd2, 1'b0, 1'b0);
    n_cmp++; if ({busy, overrun} !== 2'b10) begin n_err++; $display("FAIL start_clears: got busy,overrun=%b want 10", {busy, overrun}); end
    sb.push_back(model(raw, 4, 1'b0));
    for (int i = 0; i < 4; i++) begin
      send(d[i]);
      if (i == 2) begin
        n_cmp++; if (prod_valid !== 1'b0) begin n_err++; $display("FAIL uns_early_valid: got %b want 0", prod_valid); end
      end
    end
    n_cmp++; if (prod_valid !== 1'b1) begin n_err++; $display("FAIL uns_valid: got %b want 1", prod_valid); end
    exp_v = sb.size() > 0 ? sb.pop_front() : 32'hx;
    n_cmp++; if (product !== exp_v) begin n_err++; $display("FAIL uns_product: got %h want %h", product, exp_v); end
    accept;
    n_cmp++; if ({prod_valid, busy} !== 2'b00) begin n_err++; $display("FAIL uns_accept: got valid,busy=%b want 00", {prod_valid, busy}); end
    n_cmp++; if (product !== 32'h0000_0039) begin n_err++; $display("FAIL uns_retain: got %h want 00000039", product); end
  endtask

  task automatic test_signed;
    logic [1:0] d[4] = '{2'd1, 2'd0, 2'd3, 2'd3};
    logic [31:0] raw = '0;
    for (int i = 0; i < 4; i++) raw[2*i +: 2] = d[i];
    for (int s = 0; s < 2; s++) begin
      begin_op(5'd2, s[0], 1'b0);
      sb.push_back(model(raw, 4, s[0]));
      for (int i = 0; i < 4; i++) send(d[i]);
      exp_v = sb.size() > 0 ? sb.pop_front() : 32'hx;
      n_cmp++; if (prod_valid !== 1'b1 || product !== exp_v) begin n_err++; $display("FAIL signed_%0d: got valid=%b product=%h want 1 %h", s, prod_valid, product, exp_v); end
      accept;
    end
  endtask

  task automatic test_full_width;
    int busy_low = 0, pv = 0;
    begin_op(5'd8, 1'b0, 1'b0);
    sb.push_back(model(32'hFFFF_FFFF, 16, 1'b0));
    for (int i = 0; i < 16; i++) begin
      send(2'b11);
      if (i < 15) begin
        if (!busy) busy_low++;
        if (prod_valid) pv++;
        tick;
        if (!busy) busy_low++;
        if (prod_valid) pv++;
      end
    end
    n_cmp++; if (busy_low != 0) begin n_err++; $display("FAIL full_busy: got %0d low cycles want 0", busy_low); end
    n_cmp++; if (pv != 0) begin n_err++; $display("FAIL full_early_valid: got %0d valid cycles want 0", pv); end
    exp_v = sb.size() > 0 ? sb.pop_front() : 32'hx;
    n_cmp++; if (prod_valid !== 1'b1 || busy !== 1'b0 || product !== exp_v) begin n_err++; $display("FAIL full_product: got valid=%b busy=%b product=%h want 1 0 %h", prod_valid, busy, product, exp_v); end
    accept;
    pv = 0;
    repeat (3) begin if (prod_valid) pv++; tick; end
    n_cmp++; if (pv != 0) begin n_err++; $display("FAIL full_once: got %0d extra valid cycles want 0", pv); end
  endtask

  task automatic test_bitsize_zero;
    logic [31:0] raw = '0;
    logic [1:0] d;
    begin_op(5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) raw[2*i +: 2] = 2'($urandom_range(0, 3));
    sb.push_back(model(raw, 16, 1'b1));
    for (int i = 0; i < 16; i++) begin
      d = raw[2*i +: 2];
      send(d);
      if (i == 14) begin
        n_cmp++; if (prod_valid !== 1'b0) begin n_err++; $display("FAIL bs0_early_valid: got %b want 0", prod_valid); end
      end
    end
    exp_v = sb.size() > 0 ? sb.pop_front() : 32'hx;
    n_cmp++; if (prod_valid !== 1'b1 || product !== exp_v) begin n_err++; $display("FAIL bs0_product: got valid=%b product=%h want 1 %h", prod_valid, product, exp_v); end
    accept;
  endtask

  task automatic test_backpressure;
    logic [31:0] raw = '0;
    logic [1:0] d;
    begin_op(5'd9, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) raw[2*i +: 2] = 2'($urandom_range(0, 3));
    sb.push_back(model(raw, 16, 1'b0));
    for (int i = 0; i < 16; i++) begin d = raw[2*i +: 2]; send(d); end
    exp_v = sb.size() > 0 ? sb.pop_front() : 32'hx;
    n_cmp++; if (prod_valid !== 1'b1 || product !== exp_v) begin n_err++; $display("FAIL bp_product: got valid=%b product=%h want 1 %h", prod_valid, product, exp_v); end
    for (int c = 0; c < 5; c++) begin
      digit_valid = (c == 1 || c == 3); digit = 2'b11;
      tick;
      digit_valid = 1'b0;
      if (c == 0) begin
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL bp_no_overrun: got %b want 0", overrun); end
      end
    end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL bp_overrun: got %b want 1", overrun); end
    n_cmp++; if (prod_valid !== 1'b1 || product !== exp_v) begin n_err++; $display("FAIL bp_hold: got valid=%b product=%h want 1 %h", prod_valid, product, exp_v); end
    begin_op(5'd2, 1'b0, 1'b0);
    n_cmp++; if ({overrun, prod_valid, busy} !== 3'b001) begin n_err++; $display("FAIL bp_restart: got overrun,valid,busy=%b want 001", {overrun, prod_valid, busy}); end
  endtask

  task automatic test_restart;
    begin_op(5'd4, 1'b0, 1'b0);
    send(2'b11);
    send(2'b01);
    begin_op(5'd1, 1'b0, 1'b0);
    sb.push_back(model(32'h0000_0006, 2, 1'b0));
    send(2'b10);
    n_cmp++; if (prod_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL rs_mid: got valid=%b busy=%b want 0 1", prod_valid, busy); end
    send(2'b01);
    exp_v = sb.size() > 0 ? sb.pop_front() : 32'hx;
    n_cmp++; if (prod_valid !== 1'b1 || product !== exp_v) begin n_err++; $display("FAIL rs_product: got valid=%b product=%h want 1 %h", prod_valid, product, exp_v); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] raw = '0;
    logic [1:0] d;
    begin_op(5'd3, 1'b1, 1'b1);
    n_cmp++; if (prod_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL b2b_start: got valid=%b busy=%b want 0 1", prod_valid, busy); end
    for (int i = 0; i < 6; i++) raw[2*i +: 2] = 2'($urandom_range(0, 3));
    raw[11] = 1'b1;
    sb.push_back(model(raw, 6, 1'b1));
    for (int i = 0; i < 6; i++) begin d = raw[2*i +: 2]; send(d); end
    exp_v = sb.size() > 0 ? sb.pop_front() : 32'hx;
    n_cmp++; if (prod_valid !== 1'b1 || product !== exp_v) begin n_err++; $display("FAIL b2b_product: got valid=%b product=%h want 1 %h", prod_valid, product, exp_v); end
    accept;
  endtask

  task automatic test_async_reset;
    begin_op(5'd4, 1'b0, 1'b0);
    send(2'b11);
    send(2'b10);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (product !== 32'h0 || {prod_valid, busy, overrun} !== 3'b000) begin n_err++; $display("FAIL areset: got product=%h flags=%b want 00000000 000", product, {prod_valid, busy, overrun}); end
    #4 rst_n = 1'b1;
    tick;
    begin_op(5'd1, 1'b1, 1'b0);
    sb.push_back(model(32'h0000_000B, 2, 1'b1));
    send(2'b11);
    send(2'b10);
    exp_v = sb.size() > 0 ? sb.pop_front() : 32'hx;
    n_cmp++; if (prod_valid !== 1'b1 || product !== exp_v) begin n_err++; $display("FAIL areset_op: got valid=%b product=%h want 1 %h", prod_valid, product, exp_v); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_full_width;
    test_bitsize_zero;
    test_backpressure;
    test_restart;
    test_back_to_back;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
